branch_update_queue: RTL and testbench
======================================

Name: branch_update_queue

Overview:
- In-order queue of in-flight branch predictions, sitting directly downstream of the tournament predictor top.
- Captures each issued prediction together with its PC, GHR snapshot and local/global component outcomes.
- When the oldest branch resolves, it emits a registered training packet back to the predictor tables and choice predictor: correct, actual direction, per-component correctness.
- On a mispredict it pulses a mispredict flag, supplies the repaired GHR, and discards all younger wrong-path entries.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2
PC_W, 32, branch PC width
GHR_W, 12, global history width; matches the predictor GHR

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pred_valid  in  1  new prediction issued this cycle
pred_ready  out  1  queue not full; combinational from occupancy
pred_pc  in  PC_W  PC of predicted branch
pred_taken  in  1  final (muxed) prediction
pred_local  in  1  local component prediction
pred_global  in  1  global component prediction
pred_ghr  in  GHR_W  GHR value used to form the prediction
resolve_valid  in  1  oldest outstanding branch resolved this cycle
resolve_taken  in  1  actual direction
flush  in  1  external pipeline flush; drops all entries
upd_valid  out  1  training packet valid, one-cycle pulse
upd_pc  out  PC_W  PC of resolved branch
upd_ghr  out  GHR_W  GHR snapshot of resolved branch
upd_taken  out  1  actual direction
upd_correct  out  1  pred_taken == resolve_taken
upd_local_correct  out  1  pred_local == resolve_taken
upd_global_correct  out  1  pred_global == resolve_taken
mispredict  out  1  pulse; asserted with upd_valid when upd_correct=0
restore_ghr  out  GHR_W  {upd_ghr[GHR_W-2:0], upd_taken}; valid when mispredict=1
occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Storage: circular buffer with head and tail pointers, each $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - Full: pointers equal except MSB.
  - Empty: pointers fully equal.
  - Pointers wrap modulo 2*DEPTH.
- Push: pred_valid && pred_ready && !flush writes an entry at tail; tail increments.
  - pred_valid while full is dropped silently; no state change.
- Pop: resolve_valid && !empty && !flush reads the head entry; head increments.
  - The next cycle sets upd_valid=1 with all upd_* fields registered, giving one-cycle latency from resolve to update.
  - resolve_valid while empty is ignored; upd_valid stays 0.
- Mispredict: if the popped entry has pred_taken != resolve_taken:
  - mispredict=1 in the same cycle as upd_valid.
  - At the pop edge, tail is set to the new head, so the queue empties.
  - A push in that same cycle is also discarded as wrong-path.
- Correct resolve with a simultaneous push: both take effect; occupancy is unchanged.
- flush: highest priority. Sets tail := head (empty), suppresses any push or pop that cycle, and upd_valid=0 next cycle.
- Reset (async, any time, including mid-drain):
  - Pointers and occupancy = 0.
  - upd_valid, mispredict, all upd_* and restore_ghr = 0.
  - pred_ready=1 once reset deasserts.
  - Entry contents are not reset.
- upd_valid and mispredict are single-cycle pulses and are never held.

Optional Feature:
- Macro: BRANCH_UPDATE_QUEUE_STATS_EN.
- When defined, adds output ports:
  - stat_resolved (32): count of every upd_valid.
  - stat_mispredict (32): count of every mispredict.
  - stat_local_wins (32): count of updates where upd_local_correct && !upd_global_correct.
  - All three saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - typedef bp_entry_t packed struct {pc, ghr, taken, local_p, global_p}.
  - Constants BP_PC_W=32 and BP_GHR_W=12, shared with the GHR, tables and choice predictor.
- Sub-module bp_stat_counter: a single saturating 32-bit counter with enable, instantiated three times under the macro.

Test Plan:
1. Push 3 entries (PC 0x100/0x104/0x108, all pred_taken=1), resolve three times with taken=1 -> three upd_valid pulses, each one cycle after its resolve, in PC order; upd_correct=1; mispredict never asserted; occupancy 3->0.
2. Push 4 entries, resolve head with taken=0 (pred 1, ghr=12'h0A5) -> mispredict=1, restore_ghr=12'h14A, occupancy=0 next cycle, a same-cycle push dropped.
3. Push DEPTH+2 entries back-to-back -> pred_ready=0 after 8; the last two are dropped; draining 8 resolves returns the first 8 PCs only; pointer wrap exercised by a second fill/drain.
4. Resolve on empty queue -> no upd_valid; flush with 5 entries plus simultaneous resolve -> occupancy=0, no upd_valid.
5. Entry with pred_local=1, pred_global=0, resolve taken=1 -> upd_local_correct=1, upd_global_correct=0; with the macro defined, stat_local_wins increments by 1.
6. Assert reset asynchronously mid-drain with 3 entries -> all outputs 0 immediately, occupancy=0, pred_ready=1 after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types and widths used by the GHR, tables, choice predictor
// and the branch update queue.
package bp_pkg;

  localparam int BP_PC_W  = 32;
  localparam int BP_GHR_W = 12;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                taken;
    logic                local_p;
    logic                global_p;
  } bp_entry_t;

endpackage

// File: rtl/bp_stat_counter.sv
// Saturating 32-bit event counter with enable; holds at all-ones once reached.
module bp_stat_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions that emits training packets on resolve.
// Optional statistics counters are enabled with BRANCH_UPDATE_QUEUE_STATS_EN.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = BP_PC_W,
  parameter int GHR_W = BP_GHR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  input  logic                       pred_local,
  input  logic                       pred_global,
  input  logic [GHR_W-1:0]           pred_ghr,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic [GHR_W-1:0]           upd_ghr,
  output logic                       upd_taken,
  output logic                       upd_correct,
  output logic                       upd_local_correct,
  output logic                       upd_global_correct,
  output logic                       mispredict,
  output logic [GHR_W-1:0]           restore_ghr,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispredict,
  output logic [31:0]                stat_local_wins
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  bp_entry_t     mem_q [DEPTH];
  bp_entry_t     head_entry, new_entry;
  logic          empty, full, push, pop, mis;

  logic             upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic [GHR_W-1:0] upd_ghr_q, upd_ghr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             upd_correct_q, upd_correct_d;
  logic             upd_local_correct_q, upd_local_correct_d;
  logic             upd_global_correct_q, upd_global_correct_d;
  logic             mispredict_q, mispredict_d;
  logic [GHR_W-1:0] restore_ghr_q, restore_ghr_d;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty      = (head_q == tail_q);
  assign full       = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign pred_ready = !full;
  assign occupancy  = tail_q - head_q;

  assign push       = pred_valid && !full && !flush;
  assign pop        = resolve_valid && !empty && !flush;
  assign head_entry = mem_q[head_q[AW-1:0]];
  assign mis        = pop && (head_entry.taken != resolve_taken);

  always_comb begin
    new_entry          = '0;
    new_entry.pc       = pred_pc;
    new_entry.ghr      = pred_ghr;
    new_entry.taken    = pred_taken;
    new_entry.local_p  = pred_local;
    new_entry.global_p = pred_global;
  end

  // A mispredict squashes everything younger, including a same-cycle push.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      tail_d = head_q;
    end else begin
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (mis) begin
        tail_d = head_q + PW'(1);
      end else if (push) begin
        tail_d = tail_q + PW'(1);
      end
    end
  end

  always_comb begin
    upd_valid_d          = pop;
    mispredict_d         = mis;
    upd_pc_d             = upd_pc_q;
    upd_ghr_d            = upd_ghr_q;
    upd_taken_d          = upd_taken_q;
    upd_correct_d        = upd_correct_q;
    upd_local_correct_d  = upd_local_correct_q;
    upd_global_correct_d = upd_global_correct_q;
    restore_ghr_d        = restore_ghr_q;
    if (pop) begin
      upd_pc_d             = head_entry.pc;
      upd_ghr_d            = head_entry.ghr;
      upd_taken_d          = resolve_taken;
      upd_correct_d        = (head_entry.taken == resolve_taken);
      upd_local_correct_d  = (head_entry.local_p == resolve_taken);
      upd_global_correct_d = (head_entry.global_p == resolve_taken);
      restore_ghr_d        = {head_entry.ghr[GHR_W-2:0], resolve_taken};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q               <= '0;
      tail_q               <= '0;
      upd_valid_q          <= 1'b0;
      upd_pc_q             <= '0;
      upd_ghr_q            <= '0;
      upd_taken_q          <= 1'b0;
      upd_correct_q        <= 1'b0;
      upd_local_correct_q  <= 1'b0;
      upd_global_correct_q <= 1'b0;
      mispredict_q         <= 1'b0;
      restore_ghr_q        <= '0;
    end else begin
      head_q               <= head_d;
      tail_q               <= tail_d;
      upd_valid_q          <= upd_valid_d;
      upd_pc_q             <= upd_pc_d;
      upd_ghr_q            <= upd_ghr_d;
      upd_taken_q          <= upd_taken_d;
      upd_correct_q        <= upd_correct_d;
      upd_local_correct_q  <= upd_local_correct_d;
      upd_global_correct_q <= upd_global_correct_d;
      mispredict_q         <= mispredict_d;
      restore_ghr_q        <= restore_ghr_d;
    end
  end

  // Entry storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push && !mis) begin
      mem_q[tail_q[AW-1:0]] <= new_entry;
    end
  end

  assign upd_valid          = upd_valid_q;
  assign upd_pc             = upd_pc_q;
  assign upd_ghr            = upd_ghr_q;
  assign upd_taken          = upd_taken_q;
  assign upd_correct        = upd_correct_q;
  assign upd_local_correct  = upd_local_correct_q;
  assign upd_global_correct = upd_global_correct_q;
  assign mispredict         = mispredict_q;
  assign restore_ghr        = restore_ghr_q;

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  bp_stat_counter u_stat_resolved (
    .clock (clock),
    .reset (reset),
    .en    (upd_valid_q),
    .count (stat_resolved)
  );

  bp_stat_counter u_stat_mispredict (
    .clock (clock),
    .reset (reset),
    .en    (mispredict_q),
    .count (stat_mispredict)
  );

  bp_stat_counter u_stat_local_wins (
    .clock (clock),
    .reset (reset),
    .en    (upd_valid_q && upd_local_correct_q && !upd_global_correct_q),
    .count (stat_local_wins)
  );
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue; stats checks follow
// BRANCH_UPDATE_QUEUE_STATS_EN.
module tb_branch_update_queue;

  logic        clock;
  logic        reset;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_local;
  logic        pred_global;
  logic [11:0] pred_ghr;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [11:0] upd_ghr;
  logic        upd_taken;
  logic        upd_correct;
  logic        upd_local_correct;
  logic        upd_global_correct;
  logic        mispredict;
  logic [11:0] restore_ghr;
  logic [3:0]  occupancy;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
  logic [31:0] stat_local_wins;
  logic [31:0] snap_resolved;
  logic [31:0] snap_mispredict;
  logic [31:0] snap_local_wins;
`endif

  int checks   = 0;
  int failures = 0;

  branch_update_queue #(.DEPTH(8), .PC_W(32), .GHR_W(12)) dut (
    .clock              (clock),
    .reset              (reset),
    .pred_valid         (pred_valid),
    .pred_ready         (pred_ready),
    .pred_pc            (pred_pc),
    .pred_taken         (pred_taken),
    .pred_local         (pred_local),
    .pred_global        (pred_global),
    .pred_ghr           (pred_ghr),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .flush              (flush),
    .upd_valid          (upd_valid),
    .upd_pc             (upd_pc),
    .upd_ghr            (upd_ghr),
    .upd_taken          (upd_taken),
    .upd_correct        (upd_correct),
    .upd_local_correct  (upd_local_correct),
    .upd_global_correct (upd_global_correct),
    .mispredict         (mispredict),
    .restore_ghr        (restore_ghr),
    .occupancy          (occupancy)
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    ,
    .stat_resolved      (stat_resolved),
    .stat_mispredict    (stat_mispredict),
    .stat_local_wins    (stat_local_wins)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, clocks it in, then returns the inputs to idle.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic pt,
                               input logic pl, input logic pg, input logic [11:0] ghr,
                               input logic rv, input logic rt, input logic fl);
    pred_valid    = pv;
    pred_pc       = pc;
    pred_taken    = pt;
    pred_local    = pl;
    pred_global   = pg;
    pred_ghr      = ghr;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
    tick();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic pushEntry(input logic [31:0] pc, input logic pt, input logic pl,
                           input logic pg, input logic [11:0] ghr);
    applyStimulus(1'b1, pc, pt, pl, pg, ghr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolveHead(input logic rt);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b1, rt, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    pred_valid    = 1'b0;
    pred_pc       = 32'h0;
    pred_taken    = 1'b0;
    pred_local    = 1'b0;
    pred_global   = 1'b0;
    pred_ghr      = 12'h0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_upd_valid", 64'(upd_valid), 64'd0);
    checkOutput("rst_mispredict", 64'(mispredict), 64'd0);
    checkOutput("rst_pred_ready", 64'(pred_ready), 64'd1);
    checkOutput("rst_restore_ghr", 64'(restore_ghr), 64'd0);

    $display("[TB] in-order correct resolves");
    pushEntry(32'h100, 1'b1, 1'b1, 1'b1, 12'h001);
    pushEntry(32'h104, 1'b1, 1'b1, 1'b1, 12'h002);
    pushEntry(32'h108, 1'b1, 1'b1, 1'b1, 12'h003);
    checkOutput("t1_occ3", 64'(occupancy), 64'd3);
    checkOutput("t1_no_upd_before_resolve", 64'(upd_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      resolveHead(1'b1);
      checkOutput("t1_upd_valid", 64'(upd_valid), 64'd1);
      checkOutput("t1_upd_pc", 64'(upd_pc), 64'(32'h100 + 32'(4 * i)));
      checkOutput("t1_upd_correct", 64'(upd_correct), 64'd1);
      checkOutput("t1_mispredict", 64'(mispredict), 64'd0);
      checkOutput("t1_occ", 64'(occupancy), 64'(2 - i));
      tick();
      checkOutput("t1_pulse_drop", 64'(upd_valid), 64'd0);
    end

    $display("[TB] mispredict squash");
    pushEntry(32'h200, 1'b1, 1'b1, 1'b0, 12'h0A5);
    pushEntry(32'h204, 1'b1, 1'b1, 1'b0, 12'h0B0);
    pushEntry(32'h208, 1'b0, 1'b0, 1'b0, 12'h0B1);
    pushEntry(32'h20C, 1'b1, 1'b1, 1'b1, 12'h0B2);
    checkOutput("t2_occ4", 64'(occupancy), 64'd4);
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 12'h111, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_upd_valid", 64'(upd_valid), 64'd1);
    checkOutput("t2_mispredict", 64'(mispredict), 64'd1);
    checkOutput("t2_upd_pc", 64'(upd_pc), 64'h200);
    checkOutput("t2_upd_ghr", 64'(upd_ghr), 64'h0A5);
    checkOutput("t2_restore_ghr", 64'(restore_ghr), 64'h14A);
    checkOutput("t2_upd_correct", 64'(upd_correct), 64'd0);
    checkOutput("t2_upd_taken", 64'(upd_taken), 64'd0);
    checkOutput("t2_local_correct", 64'(upd_local_correct), 64'd0);
    checkOutput("t2_global_correct", 64'(upd_global_correct), 64'd1);
    checkOutput("t2_occ0", 64'(occupancy), 64'd0);
    tick();
    checkOutput("t2_mis_pulse_drop", 64'(mispredict), 64'd0);
    checkOutput("t2_upd_pulse_drop", 64'(upd_valid), 64'd0);
    pushEntry(32'h400, 1'b1, 1'b1, 1'b1, 12'h040);
    checkOutput("t2_occ_after_push", 64'(occupancy), 64'd1);
    resolveHead(1'b1);
    checkOutput("t2_wrong_path_dropped", 64'(upd_pc), 64'h400);

    $display("[TB] fill past full and wrap");
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_ready", 64'(pred_ready), (i < 8) ? 64'd1 : 64'd0);
      pushEntry(32'h1000 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 12'(i));
    end
    checkOutput("t3_occ_full", 64'(occupancy), 64'd8);
    checkOutput("t3_ready_full", 64'(pred_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      resolveHead(1'b1);
      checkOutput("t3_drain_valid", 64'(upd_valid), 64'd1);
      checkOutput("t3_drain_pc", 64'(upd_pc), 64'(32'h1000 + 32'(4 * i)));
    end
    tick();
    checkOutput("t3_occ_empty", 64'(occupancy), 64'd0);
    checkOutput("t3_no_extra_upd", 64'(upd_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pushEntry(32'h2000 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 12'h0);
    end
    applyStimulus(1'b1, 32'h2014, 1'b1, 1'b1, 1'b1, 12'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_push_pop_pc", 64'(upd_pc), 64'h2000);
    checkOutput("t3_push_pop_occ", 64'(occupancy), 64'd5);
    for (int i = 6; i < 9; i++) begin
      pushEntry(32'h2000 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 12'h0);
    end
    checkOutput("t3_refill_full", 64'(pred_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      resolveHead(1'b1);
      checkOutput("t3_wrap_pc", 64'(upd_pc), 64'(32'h2004 + 32'(4 * i)));
    end
    checkOutput("t3_wrap_empty", 64'(occupancy), 64'd0);

    $display("[TB] empty resolve and flush");
    tick();
    resolveHead(1'b1);
    checkOutput("t4_empty_resolve_valid", 64'(upd_valid), 64'd0);
    checkOutput("t4_empty_resolve_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pushEntry(32'h3000 + 32'(4 * i), 1'b1, 1'b1, 1'b1, 12'h0);
    end
    checkOutput("t4_occ5", 64'(occupancy), 64'd5);
    applyStimulus(1'b1, 32'h3100, 1'b1, 1'b1, 1'b1, 12'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_flush_occ", 64'(occupancy), 64'd0);
    checkOutput("t4_flush_upd", 64'(upd_valid), 64'd0);
    checkOutput("t4_flush_mis", 64'(mispredict), 64'd0);
    pushEntry(32'h3200, 1'b1, 1'b1, 1'b1, 12'h0);
    resolveHead(1'b1);
    checkOutput("t4_post_flush_pc", 64'(upd_pc), 64'h3200);

    $display("[TB] component correctness");
    tick();
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    snap_resolved   = stat_resolved;
    snap_mispredict = stat_mispredict;
    snap_local_wins = stat_local_wins;
`endif
    pushEntry(32'h500, 1'b0, 1'b1, 1'b0, 12'h7FF);
    resolveHead(1'b1);
    checkOutput("t5_upd_valid", 64'(upd_valid), 64'd1);
    checkOutput("t5_local_correct", 64'(upd_local_correct), 64'd1);
    checkOutput("t5_global_correct", 64'(upd_global_correct), 64'd0);
    checkOutput("t5_mispredict", 64'(mispredict), 64'd1);
    checkOutput("t5_restore_ghr", 64'(restore_ghr), 64'hFFF);
    tick();
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    checkOutput("t5_stat_local_wins", 64'(stat_local_wins), 64'(snap_local_wins + 32'd1));
    checkOutput("t5_stat_resolved", 64'(stat_resolved), 64'(snap_resolved + 32'd1));
    checkOutput("t5_stat_mispredict", 64'(stat_mispredict), 64'(snap_mispredict + 32'd1));
`endif

    $display("[TB] async reset mid-drain");
    pushEntry(32'h600, 1'b1, 1'b1, 1'b1, 12'h123);
    pushEntry(32'h604, 1'b0, 1'b1, 1'b1, 12'h124);
    pushEntry(32'h608, 1'b1, 1'b1, 1'b1, 12'h125);
    resolveHead(1'b0);
    checkOutput("t6_pre_reset_valid", 64'(upd_valid), 64'd1);
    checkOutput("t6_pre_reset_mis", 64'(mispredict), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_upd_valid", 64'(upd_valid), 64'd0);
    checkOutput("t6_async_mispredict", 64'(mispredict), 64'd0);
    checkOutput("t6_async_upd_pc", 64'(upd_pc), 64'd0);
    checkOutput("t6_async_upd_ghr", 64'(upd_ghr), 64'd0);
    checkOutput("t6_async_restore", 64'(restore_ghr), 64'd0);
    checkOutput("t6_async_occ", 64'(occupancy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t6_ready_after", 64'(pred_ready), 64'd1);
    checkOutput("t6_occ_after", 64'(occupancy), 64'd0);
    resolveHead(1'b1);
    checkOutput("t6_no_stale_upd", 64'(upd_valid), 64'd0);

    $display("%0d/%0d checks passed", checks - failures, checks);
    $finish;
  end

endmodule
